// File: rtl/seq_det_window_counter_if.sv
// Control, match-input and report-slot signals of the window counter.
// The master side drives stimulus and consumes reports; the slave side is the counter.
interface seq_det_window_counter_if #(
   parameter int WIN_W = 8,
   parameter int CNT_W = 8
) ();
   logic             en;
   logic             det_in;
   logic [WIN_W-1:0] win_len;
   logic [CNT_W-1:0] thresh;
   logic             rpt_ready;
   logic             rpt_valid;
   logic [CNT_W-1:0] rpt_count;
   logic             rpt_over;
   logic             rpt_sat;
   logic             rpt_drop;
   logic             busy;

   modport master (
      output en, det_in, win_len, thresh, rpt_ready,
      input  rpt_valid, rpt_count, rpt_over, rpt_sat, rpt_drop, busy
   );

   modport slave (
      input  en, det_in, win_len, thresh, rpt_ready,
      output rpt_valid, rpt_count, rpt_over, rpt_sat, rpt_drop, busy
   );
endinterface

// File: rtl/seq_det_window_counter.sv
// Counts sequence-detector match pulses over back-to-back programmable windows
// and posts one report per window through a single-entry valid/ready slot.
module seq_det_window_counter #(
   parameter int WIN_W = 8,
   parameter int CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   seq_det_window_counter_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};
   localparam logic [WIN_W-1:0] WIN_ZERO = '0;

   state_t           state_q, state_d;
   logic [WIN_W-1:0] cyc_q, cyc_d;
   logic [WIN_W-1:0] len_q, len_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] thr_q, thr_d;
   logic             sat_q, sat_d;
   logic             busy_q, busy_d;
   logic             rpt_valid_q, rpt_valid_d;
   logic [CNT_W-1:0] rpt_count_q, rpt_count_d;
   logic             rpt_over_q, rpt_over_d;
   logic             rpt_sat_q, rpt_sat_d;
   logic             rpt_drop_q, rpt_drop_d;

   logic [CNT_W-1:0] nxt;
   logic             sat_now;
   logic             win_end;
   logic             load;

   // Saturating count including this cycle's sample; sat latches on any lost match.
   always_comb begin
      nxt     = cnt_q;
      sat_now = sat_q;
      if (bus.det_in) begin
         if (cnt_q == CNT_MAX) begin
            sat_now = 1'b1;
         end else begin
            nxt = cnt_q + CNT_ONE;
         end
      end
   end

   assign win_end = (cyc_q == (len_q - WIN_ONE));

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      thr_d   = thr_q;
      sat_d   = sat_q;
      load    = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.en && (bus.win_len != WIN_ZERO)) begin
               len_d   = bus.win_len;
               thr_d   = bus.thresh;
               cyc_d   = '0;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!bus.en) begin
               cyc_d   = '0;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = IDLE;
            end else if (win_end) begin
               // Next window begins on the following cycle with freshly sampled settings.
               load  = 1'b1;
               cyc_d = '0;
               cnt_d = '0;
               sat_d = 1'b0;
               len_d = bus.win_len;
               thr_d = bus.thresh;
               if (bus.win_len == WIN_ZERO) begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = nxt;
               sat_d = sat_now;
               cyc_d = cyc_q + WIN_ONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
   end

   // Single-entry report slot: a new load always wins, overwriting unconsumed data.
   always_comb begin
      rpt_valid_d = rpt_valid_q;
      rpt_count_d = rpt_count_q;
      rpt_over_d  = rpt_over_q;
      rpt_sat_d   = rpt_sat_q;
      rpt_drop_d  = rpt_drop_q;

      if (load) begin
         rpt_valid_d = 1'b1;
         rpt_count_d = nxt;
         rpt_over_d  = (nxt >= thr_q);
         rpt_sat_d   = sat_now;
         if (rpt_valid_q && !bus.rpt_ready) begin
            rpt_drop_d = 1'b1;
         end
      end else if (rpt_valid_q && bus.rpt_ready) begin
         rpt_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cyc_q       <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         thr_q       <= '0;
         sat_q       <= 1'b0;
         busy_q      <= 1'b0;
         rpt_valid_q <= 1'b0;
         rpt_count_q <= '0;
         rpt_over_q  <= 1'b0;
         rpt_sat_q   <= 1'b0;
         rpt_drop_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cyc_q       <= cyc_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         thr_q       <= thr_d;
         sat_q       <= sat_d;
         busy_q      <= busy_d;
         rpt_valid_q <= rpt_valid_d;
         rpt_count_q <= rpt_count_d;
         rpt_over_q  <= rpt_over_d;
         rpt_sat_q   <= rpt_sat_d;
         rpt_drop_q  <= rpt_drop_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.rpt_valid = rpt_valid_q;
   assign bus.rpt_count = rpt_count_q;
   assign bus.rpt_over  = rpt_over_q;
   assign bus.rpt_sat   = rpt_sat_q;
   assign bus.rpt_drop  = rpt_drop_q;

endmodule

// File: tb/tb_seq_det_window_counter.sv
// Scoreboard bench: a window-level reference model predicts the observable outputs
// after every clock edge; a separate monitor pops and compares each prediction.
module tb_seq_det_window_counter;
  localparam int WIN_W = 8;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             busy;
    logic             valid;
    logic [CNT_W-1:0] cnt;
    logic             over;
    logic             sat;
    logic             drop;
  } obs_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  seq_det_window_counter_if #(.WIN_W(WIN_W), .CNT_W(CNT_W)) bus ();

  seq_det_window_counter #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycle = 0;

  bit   m_run;
  int   m_len, m_thr;
  int   m_samp[$];
  bit   m_valid, m_over, m_sat, m_drop;
  int   m_cnt;

  task automatic model(input bit r, input bit e, input bit d, input int wl, input int th, input bit rdy);
    bit load;
    int s, lc;
    bit lo, ls;
    load = 0; lc = 0; lo = 0; ls = 0;
    if (!r) begin
      m_run = 0; m_len = 0; m_thr = 0; m_samp.delete();
      m_valid = 0; m_cnt = 0; m_over = 0; m_sat = 0; m_drop = 0;
      return;
    end
    if (!m_run) begin
      if (e && wl != 0) begin
        m_run = 1; m_len = wl; m_thr = th; m_samp.delete();
      end
    end else if (!e) begin
      m_run = 0; m_samp.delete();
    end else begin
      m_samp.push_back(int'(d));
      if (m_samp.size() == m_len) begin
        s = 0;
        foreach (m_samp[i]) s += m_samp[i];
        lc = (s > MAXC) ? MAXC : s;
        ls = (s > MAXC);
        lo = (lc >= m_thr);
        load = 1;
        m_samp.delete();
        m_len = wl; m_thr = th;
        if (wl == 0) m_run = 0;
      end
    end
    if (load) begin
      if (m_valid && !rdy) m_drop = 1;
      m_valid = 1; m_cnt = lc; m_over = lo; m_sat = ls;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit d, input int wl, input int th, input bit rdy);
    obs_t x;
    @(negedge clk);
    #1;
    rstn          = r;
    bus.en        = e;
    bus.det_in    = d;
    bus.win_len   = WIN_W'(wl);
    bus.thresh    = CNT_W'(th);
    bus.rpt_ready = rdy;
    model(r, e, d, wl, th, rdy);
    x.busy  = m_run;
    x.valid = m_valid;
    x.cnt   = CNT_W'(m_cnt);
    x.over  = m_over;
    x.sat   = m_sat;
    x.drop  = m_drop;
    exp_q.push_back(x);
  endtask

  task automatic check_reset_state(input string tag);
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.rpt_valid !== 1'b0 || bus.rpt_count !== '0 ||
        bus.rpt_over !== 1'b0 || bus.rpt_sat !== 1'b0 || bus.rpt_drop !== 1'b0) begin
      n_bad++;
      $display("FAIL reset state (%s): busy=%b valid=%b count=%0d over=%b sat=%b drop=%b",
               tag, bus.busy, bus.rpt_valid, bus.rpt_count, bus.rpt_over, bus.rpt_sat, bus.rpt_drop);
    end
  endtask

  task automatic wait_report(input string tag, input int max_cycles);
    int k;
    k = 0;
    while (bus.rpt_valid !== 1'b1 && k < max_cycles) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (bus.rpt_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL wait expired (%s): no rpt_valid within %0d cycles", tag, max_cycles);
    end
  endtask

  obs_t act, expv;
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        act.busy  = bus.busy;
        act.valid = bus.rpt_valid;
        act.cnt   = bus.rpt_count;
        act.over  = bus.rpt_over;
        act.sat   = bus.rpt_sat;
        act.drop  = bus.rpt_drop;
        n_cmp++;
        if (act !== expv) begin
          n_bad++;
          $display("FAIL outputs cycle=%0d got busy=%b valid=%b count=%0d over=%b sat=%b drop=%b expected busy=%b valid=%b count=%0d over=%b sat=%b drop=%b",
                   cycle, act.busy, act.valid, act.cnt, act.over, act.sat, act.drop,
                   expv.busy, expv.valid, expv.cnt, expv.over, expv.sat, expv.drop);
        end
      end
    end
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL wait expired: simulation watchdog timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    bus.en = 0; bus.det_in = 0; bus.win_len = '0; bus.thresh = '0; bus.rpt_ready = 0;

    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check_reset_state("initial");

    step(1, 1, 0, 8, 2, 1);
    for (int i = 0; i < 8; i++) step(1, 1, (i == 1 || i == 4 || i == 6), 8, 2, 1);
    wait_report("basic window", 2);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 8, 2, 1);
    step(1, 0, 0, 8, 2, 1);
    step(1, 0, 0, 8, 2, 1);

    step(1, 1, 0, 20, 15, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 1, 20, 15, 1);
    wait_report("saturation window", 2);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 20, 15, 1);
    step(1, 0, 0, 20, 15, 1);

    step(1, 1, 0, 4, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, (i < 2), 4, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, (i == 0), 4, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 4, 1, 1);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 1, 1);
    for (int i = 0; i < 8; i++) step(1, 1, (i % 2 == 0), 1, 1, 1);
    step(1, 0, 0, 1, 1, 1);
    step(1, 0, 0, 1, 1, 1);

    step(1, 1, 0, 10, 1, 1);
    for (int i = 0; i < 5; i++) step(1, 1, (i == 2 || i == 3), 10, 1, 1);
    step(1, 0, 1, 10, 1, 1);
    step(1, 0, 0, 10, 1, 1);
    step(1, 1, 0, 10, 1, 1);
    for (int i = 0; i < 10; i++) step(1, 1, (i == 0 || i == 9), 10, 1, 1);
    step(1, 0, 0, 10, 1, 1);

    for (int i = 0; i < 5; i++) step(1, 1, 1, 0, 0, 1);

    step(1, 1, 1, 4, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 1, 1, 4, 0, 0);
    step(0, 1, 1, 4, 0, 0);
    step(0, 1, 1, 4, 0, 0);
    check_reset_state("mid-operation");
    step(1, 0, 0, 4, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) != 0), 1'($urandom),
           int'($urandom_range(0, 6)), int'($urandom_range(0, MAXC)), 1'($urandom));
    end

    @(negedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard not drained: %0d predictions left", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_det_window_counter.md
Name: seq_det_window_counter

Overview:
- Downstream consumer of the serial sequence-detector match output (det_in: one-cycle-per-match Moore pulse).
- Counts match pulses over a programmable window of clock cycles.
- At each window end, posts a report (count, threshold flag, saturation flag) through a valid/ready slot to the control/status logic.
- Back-to-back windows run with no gap cycles while enabled.

Parameters:
WIN_W, 8, width of window-length input and internal cycle counter
CNT_W, 8, width of match counter and reported count

Ports:
clk  input  1  clock, all logic on rising edge
rstn  input  1  reset, synchronous, active-low
en  input  1  run enable; deassert aborts current window
det_in  input  1  match pulse from sequence detector; each high cycle = one match
win_len  input  WIN_W  window length in cycles; sampled at window start
thresh  input  CNT_W  report threshold; sampled at window start
rpt_ready  input  1  consumer accepts report
rpt_valid  output  1  report slot holds unconsumed report
rpt_count  output  CNT_W  matches in completed window
rpt_over  output  1  rpt_count >= sampled thresh
rpt_sat  output  1  match counter saturated during that window
rpt_drop  output  1  sticky: an unconsumed report was overwritten
busy  output  1  FSM in RUN

Behaviour:
- Reset (rstn=0 at edge):
  - FSM goes to IDLE; cycle counter, match counter, len_q, thr_q and sat_q cleared.
  - All outputs 0.
  - Reset overrides every other event, including a window end or handshake on the same edge.
- FSM states: IDLE, RUN. busy = (state==RUN), registered.
- IDLE:
  - det_in ignored.
  - If en=1 and win_len!=0: latch len_q=win_len, thr_q=thresh; clear cyc, cnt, sat_q; go to RUN.
  - If en=1 and win_len=0: remain in IDLE, no report.
- RUN, each cycle with en=1:
  - nxt = cnt + det_in, saturating at 2^CNT_W-1.
  - Saturation flag: sat_now = sat_q | (det_in & cnt==max).
- RUN, cycle counter:
  - Window = exactly len_q consecutive RUN cycles, counted from the first cycle in RUN.
  - det_in is sampled in every one of those cycles, including the first and the last.
- RUN, not window end (cyc != len_q-1): cnt<=nxt, sat_q<=sat_now, cyc<=cyc+1.
- RUN, window end (cyc == len_q-1):
  - Load report: rpt_count<=nxt, rpt_over<=(nxt>=thr_q), rpt_sat<=sat_now, rpt_valid<=1.
  - Clear cnt, sat_q, cyc.
  - Re-sample: len_q<=win_len, thr_q<=thresh; next window starts on the following cycle.
  - If the re-sampled win_len==0: go to IDLE.
- RUN with en=0: abort.
  - Go to IDLE next edge; clear cnt, cyc, sat_q.
  - No report; det_in that cycle is discarded.
  - An existing report in the slot is unaffected.
- Report slot:
  - rpt_valid=1 and rpt_ready=1 at an edge: rpt_valid clears, unless a new report loads on the same edge, in which case valid stays 1 with the new data.
  - Window end while rpt_valid=1 and rpt_ready=0: new report overwrites the slot and rpt_drop sets.
  - rpt_drop clears only on reset.
  - rpt_count, rpt_over and rpt_sat are stable while rpt_valid=1 and no new load occurs.
  - rpt_ready while rpt_valid=0 has no effect.
- Report latency: rpt_valid rises on the edge ending the last window cycle, i.e. it is visible in the first cycle of the next window.
- Widths:
  - Compare cyc against len_q-1 with WIN_W-bit unsigned arithmetic.
  - len_q=1 means every RUN cycle is a window end.
  - rpt_over is an unsigned compare; thresh=0 always gives rpt_over=1.

Test Plan:
- Basic window: reset 2 cycles; en=1, win_len=8, thresh=2, rpt_ready=1; det_in high in RUN cycles 1,4,6 (0-based). Expect busy high for 8 cycles, then one-cycle rpt_valid with rpt_count=3, rpt_over=1, rpt_sat=0; next window starts with no gap.
- Saturation: CNT_W=4, WIN_W=8, win_len=20, det_in=1 continuously. Expect rpt_count=15, rpt_sat=1, rpt_over=1 (thresh=15); the following window reports rpt_sat=0 when det_in=0.
- Backpressure: win_len=4, rpt_ready=0, det_in pattern gives counts 2 then 1. Expect the second report to overwrite (rpt_count=1), rpt_drop=1 and sticky; rpt_ready=1 then clears rpt_valid next edge. Also check load-and-accept on the same edge keeps rpt_valid=1.
- Abort: win_len=10, det_in pulses in cycles 2,3, en=0 at cycle 5. Expect busy=0 next cycle and no rpt_valid. Re-enable: new window counts from 0 and reports only new pulses.
- Edge lengths: en=1, win_len=0 -> busy stays 0, no reports. win_len=1 with det_in alternating 1,0 -> rpt_valid every cycle, rpt_count alternating 1,0.
- Reset mid-operation: rstn=0 during RUN with rpt_valid=1 and rpt_drop=1. Expect all outputs 0 and state IDLE after the edge, with no report from the partial window.
